// File: rtl/vendor_multi.sv
// vendor_multi: multi-product coin vendor with per-item stock and serial change.
// Ports: clk/reset (sync, active-low); c/f coin strobes; p purchase with sel;
//   cancel refund; credit; out/out_item dispense; chg_c/chg_f change pulses;
//   rej coin refused; err purchase refused; led panel status; busy not idle.
module vendor_multi #(
    parameter int COIN_C     = 100,
    parameter int COIN_F     = 500,
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 2,
    parameter int PRICE_BASE = 300,
    parameter int PRICE_STEP = 200,
    parameter int CREDIT_W   = 12,
    parameter int MAX_CREDIT = 3000,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c,
    input  logic                f,
    input  logic                p,
    input  logic                cancel,
    input  logic [SEL_W-1:0]    sel,
    output logic [CREDIT_W-1:0] credit,
    output logic                out,
    output logic [SEL_W-1:0]    out_item,
    output logic                chg_c,
    output logic                chg_f,
    output logic                rej,
    output logic                err,
    output logic [1:0]          led,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_CHANGE
    } state_e;

    localparam logic [CREDIT_W:0]   CC_W  = (CREDIT_W+1)'(COIN_C);
    localparam logic [CREDIT_W:0]   CF_W  = (CREDIT_W+1)'(COIN_F);
    localparam logic [CREDIT_W:0]   MAX_W = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] CC_N  = CREDIT_W'(COIN_C);
    localparam logic [CREDIT_W-1:0] CF_N  = CREDIT_W'(COIN_F);

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        return CREDIT_W'(PRICE_BASE + int'(idx) * PRICE_STEP);
    endfunction

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [N_ITEMS];
    logic [STOCK_W-1:0]  stock_d [N_ITEMS];
    logic [SEL_W-1:0]    item_q, item_d;
    logic                out_q, out_d;
    logic                chg_c_q, chg_c_d;
    logic                chg_f_q, chg_f_d;
    logic                rej_q, rej_d;
    logic                err_q, err_d;

    logic                sel_ok;
    logic [STOCK_W-1:0]  sel_stock;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_any;
    logic                give;

    // Out-of-range selects behave as a permanently sold-out item.
    assign sel_ok    = int'(sel) < N_ITEMS;
    assign sel_stock = sel_ok ? stock_q[sel] : '0;
    assign sel_price = price_of(sel);
    assign coin_any  = c | f;
    assign coin_sum  = {1'b0, credit_q}
                     + (c ? CC_W : '0)
                     + (f ? CF_W : '0);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        item_d   = item_q;
        out_d    = 1'b0;
        chg_c_d  = 1'b0;
        chg_f_d  = 1'b0;
        rej_d    = 1'b0;
        err_d    = 1'b0;
        give     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (p) begin
                    rej_d = coin_any;
                    if (sel_stock == '0 || credit_q < sel_price) begin
                        err_d = 1'b1;
                    end else begin
                        // Price and stock are taken on acceptance so the
                        // dispense cycle already shows the remaining credit.
                        state_d      = S_VEND;
                        out_d        = 1'b1;
                        item_d       = sel;
                        credit_d     = credit_q - sel_price;
                        stock_d[sel] = sel_stock - 1'b1;
                    end
                end else if (cancel && credit_q != '0) begin
                    rej_d = coin_any;
                    give  = 1'b1;
                end else if (coin_any) begin
                    if (coin_sum <= MAX_W) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            S_VEND, S_CHANGE: begin
                rej_d = coin_any;
                if (credit_q != '0) begin
                    give = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Each change coin is emitted on the edge that keeps us in CHANGE,
        // so every pulse overlaps a busy cycle.
        if (give) begin
            state_d = S_CHANGE;
            if (credit_q >= CF_N) begin
                chg_f_d  = 1'b1;
                credit_d = credit_q - CF_N;
            end else begin
                chg_c_d  = 1'b1;
                credit_d = credit_q - CC_N;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            item_q   <= '0;
            out_q    <= 1'b0;
            chg_c_q  <= 1'b0;
            chg_f_q  <= 1'b0;
            rej_q    <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            out_q    <= out_d;
            chg_c_q  <= chg_c_d;
            chg_f_q  <= chg_f_d;
            rej_q    <= rej_d;
            err_q    <= err_d;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    always_comb begin
        led = 2'b00;
        if (sel_stock == '0) begin
            led = 2'b11;
        end else if (credit_q >= sel_price) begin
            led = 2'b10;
        end else if (credit_q != '0) begin
            led = 2'b01;
        end
    end

    assign busy     = state_q != S_IDLE;
    assign credit   = credit_q;
    assign out      = out_q;
    assign out_item = item_q;
    assign chg_c    = chg_c_q;
    assign chg_f    = chg_f_q;
    assign rej      = rej_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vendor_multi.sv
// tb_vendor_multi: directed self-checking bench for vendor_multi.
// Drives strobes one cycle at a time and samples 1ns after each rising edge.
module tb_vendor_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c = 1'b0;
    logic        f = 1'b0;
    logic        p = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [11:0] credit;
    logic        out;
    logic [1:0]  out_item;
    logic        chg_c;
    logic        chg_f;
    logic        rej;
    logic        err;
    logic [1:0]  led;
    logic        busy;

    int checks = 0;
    int failures = 0;

    vendor_multi dut (
        .clk      (clk),
        .reset    (reset),
        .c        (c),
        .f        (f),
        .p        (p),
        .cancel   (cancel),
        .sel      (sel),
        .credit   (credit),
        .out      (out),
        .out_item (out_item),
        .chg_c    (chg_c),
        .chg_f    (chg_f),
        .rej      (rej),
        .err      (err),
        .led      (led),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic ic, input logic ifc, input logic ip,
                       input logic ican, input logic [1:0] isel);
        c = ic;
        f = ifc;
        p = ip;
        cancel = ican;
        sel = isel;
        @(posedge clk);
        #1;
        c = 1'b0;
        f = 1'b0;
        p = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(0, 0, 0, 0, 2'd0);
        reset = 1'b1;
    endtask

    logic [7:0] pat;
    int         nout;

    initial begin
        #1000000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_credit", credit, 0);
        chk("rst_out", out, 0);
        chk("rst_chg", {chg_c, chg_f}, 0);
        chk("rst_rej_err", {rej, err}, 0);
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);

        // Change return after a 300 purchase from 500
        do_reset();
        cyc(0, 1, 0, 0, 2'd0);
        chk("A_credit500", credit, 500);
        cyc(0, 0, 1, 0, 2'd0);
        chk("A_out", out, 1);
        chk("A_item", out_item, 0);
        chk("A_credit200", credit, 200);
        chk("A_busy_vend", busy, 1);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            pat[i] = chg_c;
            if (i == 2) chk("A_credit_after", credit, 0);
            if (i < 3) cyc(0, 0, 0, 0, 2'd0);
        end
        chk("A_chg_pattern", pat, 8'b0000_0110);
        chk("A_busy_drop", busy, 0);

        // Refused purchase then refund
        do_reset();
        cyc(1, 0, 0, 0, 2'd1);
        cyc(1, 0, 0, 0, 2'd1);
        chk("B_led01", led, 1);
        cyc(0, 0, 1, 0, 2'd1);
        chk("B_err", err, 1);
        chk("B_no_out", out, 0);
        chk("B_credit", credit, 200);
        pat = '0;
        cyc(0, 0, 0, 1, 2'd1);
        for (int i = 0; i < 4; i++) begin
            pat[i] = chg_c;
            cyc(0, 0, 0, 0, 2'd1);
        end
        chk("B_chg_pattern", pat, 8'b0000_0011);
        chk("B_credit0", credit, 0);

        // Credit ceiling
        do_reset();
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 2'd0);
        chk("C_credit3000", credit, 3000);
        chk("C_no_rej", rej, 0);
        cyc(0, 1, 0, 0, 2'd0);
        chk("C_rej", rej, 1);
        chk("C_credit_hold", credit, 3000);
        pat = '0;
        cyc(0, 0, 0, 1, 2'd0);
        for (int i = 0; i < 8; i++) begin
            pat[i] = chg_f;
            cyc(0, 0, 0, 0, 2'd0);
        end
        chk("C_chgf_pattern", pat, 8'b0011_1111);
        chk("C_credit0", credit, 0);

        // Sold out
        do_reset();
        nout = 0;
        for (int r = 0; r < 4; r++) begin
            cyc(1, 0, 0, 0, 2'd0);
            cyc(1, 0, 0, 0, 2'd0);
            cyc(1, 0, 0, 0, 2'd0);
            if (r == 0) chk("D_led10", led, 2);
            cyc(0, 0, 1, 0, 2'd0);
            nout += int'(out);
            if (r == 3) begin
                chk("D_err", err, 1);
                chk("D_credit300", credit, 300);
            end
            cyc(0, 0, 0, 0, 2'd0);
        end
        chk("D_out_count", nout, 3);
        chk("D_led11", led, 3);
        pat = '0;
        cyc(0, 0, 0, 1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            pat[i] = chg_c;
            cyc(0, 0, 0, 0, 2'd0);
        end
        chk("D_chg_pattern", pat, 8'b0000_0111);
        chk("D_credit0", credit, 0);

        // Coin and purchase in the same cycle
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 2'd0);
        cyc(1, 0, 1, 0, 2'd0);
        chk("E_out", out, 1);
        chk("E_rej", rej, 1);
        chk("E_credit0", credit, 0);
        cyc(0, 0, 0, 0, 2'd0);
        chk("E_no_chg", {chg_c, chg_f}, 0);
        chk("E_idle", busy, 0);

        // Coin during change return
        cyc(1, 0, 0, 0, 2'd0);
        cyc(1, 0, 0, 0, 2'd0);
        cyc(0, 0, 0, 1, 2'd0);
        chk("E_chg1", chg_c, 1);
        chk("E_credit100", credit, 100);
        cyc(1, 0, 0, 0, 2'd0);
        chk("E_rej_busy", rej, 1);
        chk("E_chg2", chg_c, 1);
        chk("E_credit_busy", credit, 0);
        cyc(0, 0, 0, 0, 2'd0);
        chk("E_rej_clear", rej, 0);
        chk("E_end_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
